// File: rtl/viterbi_frame_loader.sv
// Byte-stream loader feeding the Viterbi slice stage: assembles encoder/decoder
// frames, holds the slice in reset while loading, then runs it for one serialisation pass.
module viterbi_frame_loader (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_code_rate,
  input  logic [7:0]   i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic         o_code_rate,
  output logic [127:0] o_encoder_data_frame,
  output logic [383:0] o_decoder_data_frame,
  output logic         o_slice_rst_n,
  output logic         o_en_s,
  output logic         o_tx_valid,
  output logic         o_rx_valid,
  output logic         o_busy,
  output logic         o_done
);

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned ENC_BYTES    = 16;
  localparam int unsigned DEC_BYTES_R2 = 32;
  localparam int unsigned DEC_BYTES_R3 = 48;
  localparam int unsigned RUN_CYCLES   = 128;
  localparam int unsigned ENC_W        = ENC_BYTES * BYTE_W;
  localparam int unsigned DEC_W        = DEC_BYTES_R3 * BYTE_W;
  localparam int unsigned CNT_W        = 6;
  localparam int unsigned RUN_W        = 7;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_ENC, S_LOAD_DEC, S_ARM, S_RUN, S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [RUN_W-1:0]   r_run_cnt;
  logic [ENC_W-1:0]   r_enc;
  logic [DEC_W-1:0]   r_dec;
  logic               r_code_rate;
  logic               r_ready;
  logic               r_en_s;
  logic               r_tx_valid;
  logic               r_rx_valid;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_start;
  logic               w_enc_last;
  logic               w_dec_last;
  logic               w_run_last;
  logic [CNT_W-1:0]   w_dec_last_idx;
  logic               w_ready_nxt;
  logic               w_en_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  assign w_accept       = i_valid && r_ready;
  assign w_start        = (r_state == S_IDLE) && i_start;
  assign w_dec_last_idx = r_code_rate ? CNT_W'(DEC_BYTES_R3 - 1) : CNT_W'(DEC_BYTES_R2 - 1);
  assign w_enc_last     = (r_state == S_LOAD_ENC) && w_accept && (r_byte_cnt == CNT_W'(ENC_BYTES - 1));
  assign w_dec_last     = (r_state == S_LOAD_DEC) && w_accept && (r_byte_cnt == w_dec_last_idx);
  assign w_run_last     = (r_run_cnt == RUN_W'(RUN_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:     if (i_start)    w_next_state = S_LOAD_ENC;
      S_LOAD_ENC: if (w_enc_last) w_next_state = S_LOAD_DEC;
      S_LOAD_DEC: if (w_dec_last) w_next_state = S_ARM;
      S_ARM:                      w_next_state = S_RUN;
      S_RUN:      if (w_run_last) w_next_state = S_DONE;
      S_DONE:                     w_next_state = S_IDLE;
      default:                    w_next_state = S_IDLE;
    endcase
  end

  // Output decode of the next state; registered below so outputs track the state
  always_comb begin
    w_ready_nxt = 1'b0;
    w_en_nxt    = 1'b0;
    w_busy_nxt  = (w_next_state != S_IDLE);
    w_done_nxt  = 1'b0;
    unique case (w_next_state)
      S_LOAD_ENC, S_LOAD_DEC: w_ready_nxt = 1'b1;
      S_RUN:                  w_en_nxt    = 1'b1;
      S_DONE:                 w_done_nxt  = 1'b1;
      default:                ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready    <= 1'b0;
      r_en_s     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tx_valid <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_ready    <= w_ready_nxt;
      r_en_s     <= w_en_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      // Slice outputs are registered, so valids lag the enable by one cycle
      r_tx_valid <= r_en_s;
      r_rx_valid <= (r_state == S_RUN) && !r_run_cnt[0];
    end
  end

  // Frame assembly, byte counting and rate latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_code_rate <= 1'b0;
      r_enc       <= '0;
      r_dec       <= '0;
      r_byte_cnt  <= '0;
    end else if (w_start) begin
      r_code_rate <= i_code_rate;
      r_enc       <= '0;
      r_dec       <= '0;
      r_byte_cnt  <= '0;
    end else if (w_accept && (r_state == S_LOAD_ENC)) begin
      r_enc      <= {r_enc[ENC_W-BYTE_W-1:0], i_data};
      r_byte_cnt <= w_enc_last ? '0 : r_byte_cnt + CNT_W'(1);
    end else if (w_accept && (r_state == S_LOAD_DEC)) begin
      r_dec      <= {r_dec[DEC_W-BYTE_W-1:0], i_data};
      r_byte_cnt <= w_dec_last ? '0 : r_byte_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_run_cnt <= '0;
    else if (r_state == S_RUN)  r_run_cnt <= r_run_cnt + RUN_W'(1);
    else                        r_run_cnt <= '0;
  end

  assign o_ready              = r_ready;
  assign o_code_rate          = r_code_rate;
  assign o_encoder_data_frame = r_enc;
  assign o_decoder_data_frame = r_dec;
  assign o_slice_rst_n        = r_en_s;
  assign o_en_s               = r_en_s;
  assign o_tx_valid           = r_tx_valid;
  assign o_rx_valid           = r_rx_valid;
  assign o_busy               = r_busy;
  assign o_done               = r_done;

endmodule

// File: tb/tb_viterbi_frame_loader.sv
// Randomised bench for viterbi_frame_loader against a byte-queue reference model
// and a behavioural slice-stage serialiser.
module tb_viterbi_frame_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic         i_code_rate;
  logic [7:0]   i_data;
  logic         i_valid;
  logic         o_ready;
  logic         o_code_rate;
  logic [127:0] o_encoder_data_frame;
  logic [383:0] o_decoder_data_frame;
  logic         o_slice_rst_n;
  logic         o_en_s;
  logic         o_tx_valid;
  logic         o_rx_valid;
  logic         o_busy;
  logic         o_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  viterbi_frame_loader dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_start              (i_start),
    .i_code_rate          (i_code_rate),
    .i_data               (i_data),
    .i_valid              (i_valid),
    .o_ready              (o_ready),
    .o_code_rate          (o_code_rate),
    .o_encoder_data_frame (o_encoder_data_frame),
    .o_decoder_data_frame (o_decoder_data_frame),
    .o_slice_rst_n        (o_slice_rst_n),
    .o_en_s               (o_en_s),
    .o_tx_valid           (o_tx_valid),
    .o_rx_valid           (o_rx_valid),
    .o_busy               (o_busy),
    .o_done               (o_done)
  );

  // Behavioural slice stage: loads the frame in reset, shifts MSB-first when enabled
  logic [127:0] sl_sr = '0;
  logic         sl_tx = 1'b0;
  always @(posedge clk) begin
    if (!o_slice_rst_n) sl_sr <= o_encoder_data_frame;
    else if (o_en_s) begin
      sl_tx <= sl_sr[127];
      sl_sr <= {sl_sr[126:0], 1'b0};
    end
  end

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: random bytes, 1: incrementing bytes, 2: 0xA5 encoder frame
  task automatic do_frame(input bit rate, input bit toggle, input bit disturb, input int mode);
    logic [7:0]   b[$];
    logic [127:0] exp_enc;
    logic [383:0] exp_dec;
    logic [127:0] cap;
    int n_dec, n, idx, cyc, rdy_cyc;
    int k, en_cnt, tx_cnt, rx_cnt, done_cnt, done_k, last_en, last_tx, first_tx, first_rx, bad;
    logic busy_post;
    bit   v;

    n_dec = rate ? 48 : 32;
    n     = 16 + n_dec;
    for (int i = 0; i < n; i++) begin
      case (mode)
        1:       b.push_back(8'(i));
        2:       b.push_back(i < 16 ? 8'hA5 : 8'($urandom));
        default: b.push_back(8'($urandom));
      endcase
    end
    exp_enc = '0;
    for (int i = 0; i < 16; i++) exp_enc[127 - 8*i -: 8] = b[i];
    exp_dec = '0;
    for (int j = 0; j < n_dec; j++) exp_dec[8*n_dec - 1 - 8*j -: 8] = b[16 + j];

    @(negedge clk);
    check("idle_ready", 384'(o_ready), 384'(0));
    check("idle_busy", 384'(o_busy), 384'(0));
    i_start     = 1'b1;
    i_code_rate = rate;
    @(negedge clk);
    i_start     = 1'b0;
    i_code_rate = 1'($urandom);
    check("start_busy", 384'(o_busy), 384'(1));

    idx = 0; cyc = 0; rdy_cyc = 0;
    while (idx < n && cyc < 1000) begin
      v       = toggle ? (cyc % 2 == 1) : 1'b1;
      i_valid = v;
      i_data  = v ? b[idx] : 8'($urandom);
      if (o_ready) rdy_cyc++;
      if (v && o_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    i_valid = 1'b0;
    check("bytes_accepted", 384'(idx), 384'(n));
    check("load_ready_cycles", 384'(rdy_cyc), 384'(toggle ? 2*n : n));
    check("arm_ready", 384'(o_ready), 384'(0));
    check("arm_slice_rst_n", 384'(o_slice_rst_n), 384'(0));
    check("enc_frame", 384'(o_encoder_data_frame), 384'(exp_enc));
    check("dec_frame", o_decoder_data_frame, exp_dec);
    check("code_rate", 384'(o_code_rate), 384'(rate));

    k = 0; en_cnt = 0; tx_cnt = 0; rx_cnt = 0; done_cnt = 0; done_k = -1;
    last_en = -1; last_tx = -1; first_tx = -1; first_rx = -1; bad = 0; cap = '0;
    busy_post = 1'b1;
    while (k < 400 && !(done_k >= 0 && k > done_k + 3)) begin
      if (done_k >= 0 && k == done_k + 1) busy_post = o_busy;
      if (o_en_s) begin en_cnt++; last_en = k; end
      if (o_slice_rst_n !== o_en_s) bad++;
      if (o_tx_valid) begin
        tx_cnt++; last_tx = k;
        if (first_tx < 0) first_tx = k;
        cap = {cap[126:0], sl_tx};
      end
      if (o_rx_valid) begin
        rx_cnt++;
        if (!o_tx_valid) bad++;
        if (first_rx < 0) first_rx = k;
      end
      i_start = 1'b0;
      if (o_done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
        if (disturb) i_start = 1'b1;
      end
      if (disturb) begin
        i_valid = 1'($urandom);
        i_data  = 8'($urandom);
        if (k == 60) begin
          i_start     = 1'b1;
          i_code_rate = ~rate;
        end
      end
      @(negedge clk);
      k++;
    end
    i_start = 1'b0;
    i_valid = 1'b0;

    check("run_done_seen", 384'(done_k >= 0), 384'(1));
    check("en_s_cycles", 384'(en_cnt), 384'(128));
    check("tx_valid_cycles", 384'(tx_cnt), 384'(128));
    check("rx_valid_pulses", 384'(rx_cnt), 384'(64));
    check("done_pulses", 384'(done_cnt), 384'(1));
    check("done_after_last_en", 384'(done_k), 384'(last_en + 1));
    check("last_tx_at_done", 384'(last_tx), 384'(done_k));
    check("first_rx_with_tx", 384'(first_rx), 384'(first_tx));
    check("align_violations", 384'(bad), 384'(0));
    check("busy_after_done", 384'(busy_post), 384'(0));
    check("serial_tx_bits", 384'(cap), 384'(exp_enc));
    check("code_rate_held", 384'(o_code_rate), 384'(rate));
    check("enc_frame_held", 384'(o_encoder_data_frame), 384'(exp_enc));
    check("dec_frame_held", o_decoder_data_frame, exp_dec);
  endtask

  task automatic abort_load(input bit rate);
    int idx, cyc;
    @(negedge clk);
    i_start     = 1'b1;
    i_code_rate = rate;
    @(negedge clk);
    i_start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 20 && cyc < 200) begin
      i_valid = 1'b1;
      i_data  = 8'($urandom);
      if (o_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    i_valid = 1'b0;
    check("abort_bytes", 384'(idx), 384'(20));
    #2 rst = 1'b0;
    #1;
    check("abort_ready", 384'(o_ready), 384'(0));
    check("abort_busy", 384'(o_busy), 384'(0));
    check("abort_enc", 384'(o_encoder_data_frame), 384'(0));
    check("abort_dec", o_decoder_data_frame, 384'(0));
    check("abort_rate", 384'(o_code_rate), 384'(0));
    check("abort_slice", 384'({o_slice_rst_n, o_en_s, o_done}), 384'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 384'({o_done, o_busy}), 384'(0));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; i_start = 1'b0; i_code_rate = 1'b0; i_data = '0; i_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst     = 1'b1;
    i_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("reset_ready", 384'(o_ready), 384'(0));
    check("reset_busy", 384'(o_busy), 384'(0));
    check("reset_misc", 384'({o_code_rate, o_slice_rst_n, o_en_s, o_tx_valid, o_rx_valid, o_done}), 384'(0));
    check("reset_enc", 384'(o_encoder_data_frame), 384'(0));
    check("reset_dec", o_decoder_data_frame, 384'(0));
    i_valid = 1'b0;

    do_frame(1'b0, 1'b0, 1'b0, 1);
    do_frame(1'b1, 1'b1, 1'b1, 0);
    abort_load(1'($urandom));
    do_frame(1'b1, 1'b0, 1'b0, 0);
    for (int t = 0; t < 3; t++) do_frame(1'($urandom), 1'($urandom), 1'($urandom), 0);
    do_frame(1'b0, 1'b0, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
